// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage pipeline.
// Control and forwarding outputs are combinational; the last action, perf counters and watchdog are registered.
module pipeline_hazard_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255,
    parameter int ZR      = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_uses_rm,
    input  logic [4:0]       ex_rn,
    input  logic [4:0]       ex_rm,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic [4:0]       mem_rd,
    input  logic [4:0]       wb_rd,
    input  logic             mem_regwrite,
    input  logic             wb_regwrite,
    input  logic             br_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             pc_sel_br,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_bubble,
    output logic             pipe_hold,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout
);

    localparam int         WC_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [4:0] ZR_IDX = 5'(ZR);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        FLUSH    = 2'b10,
        MEM_WAIT = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;
    logic              load_use;
    logic              stall_inc;
    logic              flush_inc;

    assign load_use = ex_memread && (ex_rd != ZR_IDX) &&
                      ((ex_rd == id_rn) || (id_uses_rm && (ex_rd == id_rm)));

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        pc_sel_br    = 1'b0;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        pipe_hold    = 1'b0;
        fwd_a        = 2'b00;
        fwd_b        = 2'b00;
        state_d      = RUN;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        if (reset) begin
            if (mem_busy) begin
                // Whole pipe frozen; a taken branch stays latched in EX/MEM until memory returns.
                pipe_hold  = 1'b1;
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                stall_inc  = 1'b1;
                state_d    = MEM_WAIT;
            end else if (br_taken) begin
                pc_sel_br    = 1'b1;
                ifid_flush   = 1'b1;
                idex_bubble  = 1'b1;
                exmem_bubble = 1'b1;
                flush_inc    = 1'b1;
                state_d      = FLUSH;
            end else if (load_use) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
                stall_inc   = 1'b1;
                state_d     = LU_STALL;
            end

            if (mem_regwrite && (mem_rd != ZR_IDX) && (mem_rd == ex_rn))
                fwd_a = 2'b10;
            else if (wb_regwrite && (wb_rd != ZR_IDX) && (wb_rd == ex_rn))
                fwd_a = 2'b01;

            if (mem_regwrite && (mem_rd != ZR_IDX) && (mem_rd == ex_rm))
                fwd_b = 2'b10;
            else if (wb_regwrite && (wb_rd != ZR_IDX) && (wb_rd == ex_rm))
                fwd_b = 2'b01;
        end
    end

    always_comb begin
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        wait_cnt_d    = '0;
        mem_timeout_d = mem_timeout_q;
        if (stall_inc && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush_inc && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + 1'b1;
        if (mem_busy) begin
            // wait_cnt parks at TIMEOUT; any further busy cycle trips the sticky flag.
            if (wait_cnt_q == WC_MAX)
                mem_timeout_d = 1'b1;
            else
                wait_cnt_d = wait_cnt_q + 1'b1;
            if (wait_cnt_q == WC_MAX)
                wait_cnt_d = wait_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= RUN;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign state       = state_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed hazard scenarios plus random traffic against a rule-level model.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 3;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [4:0] id_rn, id_rm, ex_rn, ex_rm, ex_rd, mem_rd, wb_rd;
    logic       id_uses_rm, ex_memread, mem_regwrite, wb_regwrite, br_taken, mem_busy;
    logic       pc_write, pc_sel_br, ifid_write, ifid_flush, idex_bubble, exmem_bubble, pipe_hold;
    logic [1:0] fwd_a, fwd_b, state;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic       mem_timeout;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .ZR(31)) dut (
        .clk(clk), .reset(reset),
        .id_rn(id_rn), .id_rm(id_rm), .id_uses_rm(id_uses_rm),
        .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_rd(ex_rd), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
        .br_taken(br_taken), .mem_busy(mem_busy),
        .pc_write(pc_write), .pc_sel_br(pc_sel_br), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble), .pipe_hold(pipe_hold),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_timeout(mem_timeout)
    );

    int total = 0;
    int bad   = 0;

    // Reference state: last action, counters, length of the current busy run, sticky timeout.
    int m_state = 0, m_stall = 0, m_flush = 0, m_run = 0;
    bit m_to = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int event_now();
        bit lu;
        lu = ex_memread && ex_rd != 31 && (ex_rd == id_rn || (id_uses_rm && ex_rd == id_rm));
        if (!reset)   return 0;
        if (mem_busy) return 3;
        if (br_taken) return 2;
        if (lu)       return 1;
        return 0;
    endfunction

    function automatic logic [1:0] fsel(input logic [4:0] src);
        if (!reset) return 2'b00;
        if (mem_regwrite && mem_rd != 31 && mem_rd == src) return 2'b10;
        if (wb_regwrite && wb_rd != 31 && wb_rd == src) return 2'b01;
        return 2'b00;
    endfunction

    // Compare everything, clock once, advance the model. Called with inputs driven just after negedge.
    task automatic cycle();
        int ev;
        logic [6:0] ectl;
        #1;
        ev = event_now();
        // {pc_write, ifid_write, pc_sel_br, ifid_flush, idex_bubble, exmem_bubble, pipe_hold}
        case (ev)
            3:       ectl = 7'b0000001;
            2:       ectl = 7'b1111110;
            1:       ectl = 7'b0000100;
            default: ectl = 7'b1100000;
        endcase
        chk("ctl", {pc_write, ifid_write, pc_sel_br, ifid_flush, idex_bubble, exmem_bubble, pipe_hold}, ectl);
        chk("fwd_a", fwd_a, fsel(ex_rn));
        chk("fwd_b", fwd_b, fsel(ex_rm));
        chk("state", state, m_state);
        chk("stall_cnt", stall_cnt, m_stall);
        chk("flush_cnt", flush_cnt, m_flush);
        chk("mem_timeout", mem_timeout, m_to);
        @(posedge clk);
        if (!reset) begin
            m_state = 0; m_stall = 0; m_flush = 0; m_run = 0; m_to = 0;
        end else begin
            m_state = ev;
            if (ev == 1 || ev == 3) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
            if (ev == 2)            m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
            if (mem_busy) begin
                m_run++;
                if (m_run > TIMEOUT) m_to = 1;
            end else begin
                m_run = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        id_rn = 5'd1; id_rm = 5'd2; id_uses_rm = 0;
        ex_rn = 5'd10; ex_rm = 5'd11; ex_rd = 5'd12; ex_memread = 0;
        mem_rd = 5'd20; wb_rd = 5'd21; mem_regwrite = 0; wb_regwrite = 0;
        br_taken = 0; mem_busy = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 0;
        cycle();
        reset = 1;
    endtask

    function automatic logic [4:0] rreg();
        case ($urandom_range(0, 3))
            0:       return 5'd3;
            1:       return 5'd31;
            default: return 5'($urandom_range(0, 7));
        endcase
    endfunction

    initial begin
        int busy_left;
        reset = 0;
        idle();
        @(negedge clk);
        // Reset-state outputs while reset is held.
        mem_busy = 1; br_taken = 1;
        #1;
        chk("rst_pcw", {pc_write, ifid_write, pipe_hold, pc_sel_br}, 4'b1100);
        cycle();
        cycle();
        chk("rst_cnt", {state, stall_cnt, flush_cnt, mem_timeout}, '0);
        idle();
        reset = 1;

        // 1: load-use on id_rn.
        ex_memread = 1; ex_rd = 5'd3; id_rn = 5'd3;
        #1;
        chk("t1_ctl", {pc_write, ifid_write, idex_bubble}, 3'b001);
        cycle();
        idle();
        cycle();
        chk("t1_cnt", {state, stall_cnt}, {2'b00, 4'd1});
        do_reset();

        // 2: XZR never a hazard nor a forward source.
        ex_memread = 1; ex_rd = 5'd31; id_rn = 5'd31;
        mem_rd = 5'd31; ex_rn = 5'd31; mem_regwrite = 1;
        #1;
        chk("t2_ctl", {pc_write, idex_bubble, fwd_a}, 4'b1000);
        cycle();
        idle();

        // 3: forwarding priority.
        mem_rd = 5'd5; wb_rd = 5'd5; ex_rn = 5'd5; ex_rm = 5'd5;
        mem_regwrite = 1; wb_regwrite = 1;
        #1; chk("t3_both", {fwd_a, fwd_b}, 4'b1010);
        cycle();
        mem_regwrite = 0;
        #1; chk("t3_wb", {fwd_a, fwd_b}, 4'b0101);
        cycle();
        idle();

        // 4: branch beats concurrent load-use.
        do_reset();
        br_taken = 1; ex_memread = 1; ex_rd = 5'd3; id_rn = 5'd3;
        #1;
        chk("t4_ctl", {pc_sel_br, ifid_flush, idex_bubble, exmem_bubble, pc_write}, 5'b11111);
        cycle();
        idle();
        cycle();
        chk("t4_cnt", {flush_cnt, stall_cnt}, {4'd1, 4'd0});

        // 5: memory wait with a pending branch, then the flush.
        do_reset();
        mem_busy = 1; br_taken = 1;
        for (int i = 0; i < 4; i++) begin
            #1; chk("t5_hold", {pipe_hold, pc_sel_br}, 2'b10);
            cycle();
        end
        chk("t5_stall", stall_cnt, 4'd4);
        mem_busy = 0;
        #1; chk("t5_flush", pc_sel_br, 1'b1);
        cycle();
        idle();
        cycle();
        chk("t5_fcnt", {state, flush_cnt}, {2'b00, 4'd1});

        // 6: watchdog.
        do_reset();
        mem_busy = 1;
        for (int i = 1; i <= 6; i++) begin
            cycle();
            chk("t6_to", mem_timeout, (i >= 4) ? 1'b1 : 1'b0);
        end
        mem_busy = 0;
        cycle();
        chk("t6_sticky", mem_timeout, 1'b1);
        do_reset();
        chk("t6_rst", {mem_timeout, stall_cnt, state}, '0);

        // Saturation of stall_cnt.
        ex_memread = 1; ex_rd = 5'd4; id_rm = 5'd4; id_uses_rm = 1;
        for (int i = 0; i < 20; i++) cycle();
        chk("sat", stall_cnt, 4'd15);
        idle();
        do_reset();

        // Random traffic.
        busy_left = 0;
        for (int n = 0; n < 3000; n++) begin
            id_rn = rreg(); id_rm = rreg(); ex_rn = rreg(); ex_rm = rreg();
            ex_rd = rreg(); mem_rd = rreg(); wb_rd = rreg();
            id_uses_rm   = 1'($urandom_range(0, 1));
            ex_memread   = 1'($urandom_range(0, 1));
            mem_regwrite = 1'($urandom_range(0, 1));
            wb_regwrite  = 1'($urandom_range(0, 1));
            br_taken     = ($urandom_range(0, 5) == 0);
            if (busy_left == 0 && $urandom_range(0, 15) == 0) busy_left = $urandom_range(1, 7);
            mem_busy = (busy_left > 0);
            if (busy_left > 0) busy_left--;
            reset = ($urandom_range(0, 79) != 0);
            cycle();
        end
        reset = 1;
        idle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
